aes_job_arbiter: RTL and testbench

Shares one AES encrypt core (aes_cipher_top) and one AES decrypt core (aes_inv_cipher_top) between an encrypt requester and a decrypt requester. It accepts one 128-bit block at a time and round-robins between the two requesters. For each block it sequences core reset, the decrypt key load when needed, and the load pulse. It then waits for the core's done, and holds the result on a valid/ready output port. It sits between the SDRAM read/write sequencers and the two cipher cores, and takes over the ld/kld/rst sequencing from the sequencers.

---
 rtl/aes_job_arbiter_if.sv | 41 ++++
 rtl/aes_job_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_aes_job_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_job_arbiter_if.sv
// Bundle between aes_job_arbiter and its requesters, the two cipher cores and the result consumer.
// master = arbiter side, slave = environment side.
interface aes_job_arbiter_if;
    logic         iREQ_E;
    logic         iREQ_D;
    logic [127:0] iDATA_E;
    logic [127:0] iDATA_D;
    logic         oACK_E;
    logic         oACK_D;
    logic [127:0] iKEY;
    logic         oCORE_RST_n;
    logic         oLD_E;
    logic         oLD_D;
    logic         oKLD_D;
    logic [127:0] oTEXT_IN;
    logic         iE_DONE;
    logic         iD_DONE;
    logic [127:0] iE_TEXT;
    logic [127:0] iD_TEXT;
    logic         oRES_VALID;
    logic [127:0] oRES_DATA;
    logic         oRES_MODE;
    logic         iRES_READY;
    logic         oBUSY;
    logic [15:0]  oBLK_CNT;
    logic         oERR;

    modport master (
        input  iREQ_E, iREQ_D, iDATA_E, iDATA_D, iKEY,
        input  iE_DONE, iD_DONE, iE_TEXT, iD_TEXT, iRES_READY,
        output oACK_E, oACK_D, oCORE_RST_n, oLD_E, oLD_D, oKLD_D, oTEXT_IN,
        output oRES_VALID, oRES_DATA, oRES_MODE, oBUSY, oBLK_CNT, oERR
    );

    modport slave (
        output iREQ_E, iREQ_D, iDATA_E, iDATA_D, iKEY,
        output iE_DONE, iD_DONE, iE_TEXT, iD_TEXT, iRES_READY,
        input  oACK_E, oACK_D, oCORE_RST_n, oLD_E, oLD_D, oKLD_D, oTEXT_IN,
        input  oRES_VALID, oRES_DATA, oRES_MODE, oBUSY, oBLK_CNT, oERR
    );
endinterface

// File: rtl/aes_job_arbiter.sv
// Round-robin job arbiter sharing one AES encrypt core and one AES decrypt core.
// Define AES_WATCHDOG_EN to add the RUN watchdog, the sticky oERR flag and the ABORT state.
module aes_job_arbiter #(
    parameter int unsigned KEYWAIT_CYC = 12,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input logic               iCLK,
    input logic               iRST,
    aes_job_arbiter_if.master bus
);
    localparam int unsigned CNT_MAX = (KEYWAIT_CYC > TIMEOUT_CYC) ? KEYWAIT_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, CRST, KLD, KWAIT, LOAD, RUN, OUT
`ifdef AES_WATCHDOG_EN
        , ABORT
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;       // 0 = encrypt, 1 = decrypt
    logic               last_q, last_d;
    logic               key_valid_q, key_valid_d;
    logic [127:0]       key_q, key_d;
    logic [127:0]       text_q, text_d;
    logic [127:0]       res_data_q, res_data_d;
    logic               res_mode_q, res_mode_d;
    logic [15:0]        blk_q, blk_d;
    logic               ack_e_q, ack_e_d;
    logic               ack_d_q, ack_d_d;
    logic               rst_n_q, rst_n_d;
    logic               ld_e_q, ld_e_d;
    logic               ld_d_q, ld_d_d;
    logic               kld_q, kld_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               grant;
`ifdef AES_WATCHDOG_EN
    logic               err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        last_d      = last_q;
        key_valid_d = key_valid_q;
        key_d       = key_q;
        text_d      = text_q;
        res_data_d  = res_data_q;
        res_mode_d  = res_mode_q;
        blk_d       = blk_q;
        ack_e_d     = 1'b0;
        ack_d_d     = 1'b0;
        grant       = 1'b0;
`ifdef AES_WATCHDOG_EN
        err_d       = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.iREQ_E || bus.iREQ_D) begin
                    // Contention goes to the mode that did not win last time.
                    grant   = bus.iREQ_D && (!bus.iREQ_E || !last_q);
                    mode_d  = grant;
                    last_d  = grant;
                    text_d  = grant ? bus.iDATA_D : bus.iDATA_E;
                    ack_e_d = !grant;
                    ack_d_d = grant;
                    cnt_d   = '0;
                    state_d = CRST;
                end
            end
            CRST: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = (mode_q && (!key_valid_q || bus.iKEY != key_q)) ? KLD : LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            KLD: begin
                key_d       = bus.iKEY;
                key_valid_d = 1'b1;
                cnt_d       = '0;
                state_d     = KWAIT;
            end
            KWAIT: begin
                if (cnt_q == CNT_W'(KEYWAIT_CYC - 1)) begin
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (mode_q ? bus.iD_DONE : bus.iE_DONE) begin
                    res_data_d = mode_q ? bus.iD_TEXT : bus.iE_TEXT;
                    res_mode_d = mode_q;
                    state_d    = OUT;
                end
`ifdef AES_WATCHDOG_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ABORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            OUT: begin
                if (bus.iRES_READY) begin
                    blk_d   = blk_q + 16'd1;
                    state_d = IDLE;
                end
            end
`ifdef AES_WATCHDOG_EN
            ABORT: begin
                key_valid_d = 1'b0;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Strobes are registered from the next state so they line up with the state itself.
        rst_n_d = (state_d != CRST)
`ifdef AES_WATCHDOG_EN
                  && (state_d != ABORT)
`endif
                  ;
        ld_e_d  = (state_d == LOAD) && !mode_d;
        ld_d_d  = (state_d == LOAD) && mode_d;
        kld_d   = (state_d == KLD);
        valid_d = (state_d == OUT);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            last_q      <= 1'b1;
            key_valid_q <= 1'b0;
            key_q       <= '0;
            text_q      <= '0;
            res_data_q  <= '0;
            res_mode_q  <= 1'b0;
            blk_q       <= '0;
            ack_e_q     <= 1'b0;
            ack_d_q     <= 1'b0;
            rst_n_q     <= 1'b1;
            ld_e_q      <= 1'b0;
            ld_d_q      <= 1'b0;
            kld_q       <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef AES_WATCHDOG_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            last_q      <= last_d;
            key_valid_q <= key_valid_d;
            key_q       <= key_d;
            text_q      <= text_d;
            res_data_q  <= res_data_d;
            res_mode_q  <= res_mode_d;
            blk_q       <= blk_d;
            ack_e_q     <= ack_e_d;
            ack_d_q     <= ack_d_d;
            rst_n_q     <= rst_n_d;
            ld_e_q      <= ld_e_d;
            ld_d_q      <= ld_d_d;
            kld_q       <= kld_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
`ifdef AES_WATCHDOG_EN
            err_q       <= err_d;
`endif
        end
    end

    assign bus.oACK_E      = ack_e_q;
    assign bus.oACK_D      = ack_d_q;
    assign bus.oCORE_RST_n = rst_n_q;
    assign bus.oLD_E       = ld_e_q;
    assign bus.oLD_D       = ld_d_q;
    assign bus.oKLD_D      = kld_q;
    assign bus.oTEXT_IN    = text_q;
    assign bus.oRES_VALID  = valid_q;
    assign bus.oRES_DATA   = res_data_q;
    assign bus.oRES_MODE   = res_mode_q;
    assign bus.oBUSY       = busy_q;
    assign bus.oBLK_CNT    = blk_q;
`ifdef AES_WATCHDOG_EN
    assign bus.oERR        = err_q;
`else
    assign bus.oERR        = 1'b0;
`endif
endmodule

// File: tb/tb_aes_job_arbiter.sv
// Randomized self-checking bench for aes_job_arbiter against a transaction-level model
// of the arbitration, key caching, result and block-count rules.
module tb_aes_job_arbiter;
    localparam int unsigned KW = 12;
    localparam int unsigned TO = 64;
    localparam logic [127:0] TV_PT  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] TV_KEY = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] TV_CT  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_job_arbiter_if bus();

    aes_job_arbiter #(.KEYWAIT_CYC(KW), .TIMEOUT_CYC(TO)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int kld_mon = 0;

    // Model state: last winner (1 = D), cached decrypt key, block count, error flag.
    bit           m_last;
    bit           m_kv;
    logic [127:0] m_key;
    logic [15:0]  m_blk;
    bit           m_err;
    logic [127:0] key_a, key_b;

    always @(negedge clk) if (bus.oKLD_D === 1'b1) kld_mon++;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Stand-in cipher: real AES only for the reference vector.
    function automatic logic [127:0] core_f(input bit dec, input logic [127:0] d, input logic [127:0] k);
        if (!dec && d == TV_PT && k == TV_KEY) return TV_CT;
        return dec ? (d ^ {k[63:0], k[127:64]}) : (d ^ k ^ 128'hA5A5_0F0F_5A5A_F0F0_3C3C_C3C3_1234_5678);
    endfunction

    task automatic model_reset();
        m_last = 1'b1;
        m_kv   = 1'b0;
        m_key  = '0;
        m_blk  = '0;
        m_err  = 1'b0;
    endtask

    task automatic raise(input bit dec);
        if (dec) begin
            bus.iREQ_D  = 1'b1;
            bus.iDATA_D = rnd128();
        end else begin
            bus.iREQ_E  = 1'b1;
            bus.iDATA_E = rnd128();
        end
    endtask

    task automatic drive_done(input bit dec, input bit v, input logic [127:0] t);
        if (dec) begin
            bus.iD_DONE = v;
            bus.iD_TEXT = t;
        end else begin
            bus.iE_DONE = v;
            bus.iE_TEXT = t;
        end
    endtask

    task automatic clear_done();
        bus.iE_DONE = 1'b0;
        bus.iD_DONE = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, 128'({bus.oACK_E, bus.oACK_D, bus.oLD_E, bus.oLD_D, bus.oKLD_D,
                                 bus.oRES_VALID, bus.oRES_MODE, bus.oBUSY, bus.oERR,
                                 bus.oCORE_RST_n}), 128'd1);
        chk({tag, "_text"}, bus.oTEXT_IN, '0);
        chk({tag, "_res"}, bus.oRES_DATA, '0);
        chk({tag, "_cnt"}, 128'(bus.oBLK_CNT), '0);
    endtask

    // One job from grant to result hand-off. kind: 0 normal, 1 reset in RUN, 2 watchdog timeout.
    task automatic serve(input int unsigned rdy_wait, input int unsigned lat, input int unsigned kind);
        bit           g;
        bit           need_kld;
        logic [127:0] d, res;
        int unsigned  n;

        if (bus.iREQ_E && bus.iREQ_D) g = !m_last;
        else                          g = bus.iREQ_D;
        d   = g ? bus.iDATA_D : bus.iDATA_E;
        res = core_f(g, d, bus.iKEY);

        n = 0;
        while (!(bus.oACK_E || bus.oACK_D) && n < 8) begin
            tick();
            n++;
        end
        chk("ack_latency", 128'(n), 128'd1);
        chk("ack_sel", 128'({bus.oACK_E, bus.oACK_D}), g ? 128'd1 : 128'd2);
        chk("text_in", bus.oTEXT_IN, d);
        chk("crst_a", 128'({bus.oCORE_RST_n, bus.oBUSY}), 128'd1);
        m_last = g;
        if (g) bus.iREQ_D = 1'b0;
        else   bus.iREQ_E = 1'b0;

        tick();
        chk("crst_b", 128'({bus.oCORE_RST_n, bus.oACK_E, bus.oACK_D}), 128'd0);
        tick();
        need_kld = g && (!m_kv || bus.iKEY != m_key);
        chk("kld", 128'(bus.oKLD_D), 128'(need_kld));
        if (need_kld) begin
            m_kv  = 1'b1;
            m_key = bus.iKEY;
            for (int i = 0; i < int'(KW); i++) begin
                tick();
                chk("kwait", 128'({bus.oKLD_D, bus.oLD_E, bus.oLD_D}), 128'd0);
            end
            tick();
        end
        chk("ld", 128'({bus.oLD_E, bus.oLD_D}), g ? 128'd1 : 128'd2);
        chk("crst_rel", 128'(bus.oCORE_RST_n), 128'd1);

        drive_done(g, 1'($urandom_range(0, 1)), ~res);
        tick();
        clear_done();
        chk("load_done_ignored", 128'(bus.oRES_VALID), 128'd0);

        if (kind == 1) begin
            tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk_reset("rst_mid_run");
            drive_done(g, 1'b1, res);
            tick();
            clear_done();
            chk("done_after_rst", 128'({bus.oRES_VALID, bus.oBUSY}), 128'd0);
            model_reset();
            return;
        end

        if (kind == 2) begin
            for (int i = 1; i < int'(TO); i++) begin
                tick();
                chk("wd_run", 128'({bus.oERR, bus.oRES_VALID, bus.oCORE_RST_n}), 128'd1);
            end
            m_err = 1'b1;
            m_kv  = 1'b0;
            tick();
            chk("wd_abort_a", 128'({bus.oERR, bus.oCORE_RST_n, bus.oBUSY}), 128'b101);
            tick();
            chk("wd_abort_b", 128'({bus.oERR, bus.oCORE_RST_n, bus.oBUSY}), 128'b101);
            tick();
            chk("wd_idle", 128'({bus.oERR, bus.oCORE_RST_n, bus.oBUSY, bus.oRES_VALID}), 128'b1100);
            chk("wd_cnt", 128'(bus.oBLK_CNT), 128'(m_blk));
            return;
        end

        for (int i = 0; i < int'(lat); i++) begin
            drive_done(!g, 1'($urandom_range(0, 1)), ~res ^ 128'h1);
            tick();
            chk("run_wait", 128'({bus.oRES_VALID, bus.oACK_E, bus.oACK_D, bus.oLD_E, bus.oLD_D}), 128'd0);
        end
        clear_done();
        drive_done(g, 1'b1, res);
        tick();
        clear_done();
        chk("res_valid", 128'(bus.oRES_VALID), 128'd1);
        chk("res_data", bus.oRES_DATA, res);
        chk("res_mode", 128'(bus.oRES_MODE), 128'(g));

        for (int i = 0; i < int'(rdy_wait); i++) begin
            tick();
            chk("bp_hold", 128'({bus.oRES_VALID, bus.oACK_E, bus.oACK_D, bus.oBUSY}), 128'b1001);
            chk("bp_data", bus.oRES_DATA, res);
            chk("bp_cnt", 128'(bus.oBLK_CNT), 128'(m_blk));
        end
        bus.iRES_READY = 1'b1;
        tick();
        bus.iRES_READY = 1'b0;
        m_blk = m_blk + 16'd1;
        chk("done_cnt", 128'(bus.oBLK_CNT), 128'(m_blk));
        chk("done_idle", 128'({bus.oRES_VALID, bus.oBUSY, bus.oERR}), 128'(m_err));
    endtask

    initial begin
        bus.iREQ_E     = 1'b0;
        bus.iREQ_D     = 1'b0;
        bus.iDATA_E    = '0;
        bus.iDATA_D    = '0;
        bus.iKEY       = '0;
        bus.iE_DONE    = 1'b0;
        bus.iD_DONE    = 1'b0;
        bus.iE_TEXT    = '0;
        bus.iD_TEXT    = '0;
        bus.iRES_READY = 1'b0;
        key_a = rnd128();
        key_b = rnd128();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_reset("reset");
        model_reset();

        // Reference vector: done 11 cycles after ld.
        bus.iKEY    = TV_KEY;
        bus.iREQ_E  = 1'b1;
        bus.iDATA_E = TV_PT;
        serve(3, 10, 0);
        chk("tv_ct", bus.oRES_DATA, TV_CT);
        chk("tv_mode", 128'(bus.oRES_MODE), 128'd0);
        chk("tv_cnt", 128'(bus.oBLK_CNT), 128'd1);

        // Decrypt key caching.
        bus.iKEY = key_a;
        for (int j = 0; j < 3; j++) begin
            if (j == 2) bus.iKEY = key_b;
            raise(1'b1);
            serve(1, 4, 0);
            chk("kld_pulses", 128'(kld_mon), (j < 2) ? 128'd1 : 128'd2);
        end

        // Contention straight after reset: E, D, E, D.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk_reset("reset2");
        raise(1'b0);
        raise(1'b1);
        serve(0, 2, 0);
        raise(1'b0);
        serve(0, 2, 0);
        raise(1'b1);
        serve(0, 2, 0);
        serve(0, 2, 0);

        // Backpressure with a competing request pending.
        raise(1'b0);
        raise(1'b1);
        serve(20, 6, 0);
        serve(0, 3, 0);

        // Reset during RUN, then a normal job.
        raise(1'b0);
        serve(0, 0, 1);
        raise(1'b1);
        serve(2, 5, 0);

`ifdef AES_WATCHDOG_EN
        raise(1'b0);
        serve(0, 0, 2);
        raise(1'b0);
        serve(1, 3, 0);
`endif

        for (int it = 0; it < 40; it++) begin
            if (!bus.iREQ_E && !bus.iREQ_D) begin
                case ($urandom_range(0, 2))
                    0:       raise(1'b0);
                    1:       raise(1'b1);
                    default: begin
                        raise(1'b0);
                        raise(1'b1);
                    end
                endcase
            end
            if ($urandom_range(0, 3) == 0) bus.iKEY = ($urandom_range(0, 1) == 1) ? key_a : key_b;
            serve($urandom_range(0, 4), $urandom_range(0, 15), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
